control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcoded fetch/decode/execute FSM for the 8-bit single-bus CPU.
- Decodes the instruction register and drives every datapath control strobe: register file, ALU, MAR, IR, program counter, and memory.
- Clocked on port clk; the top level drives it from clk_b, so the control word is stable before the datapath's rising edge.
- Guarantees that at most one bus driver is enabled per cycle.

Parameters:
- REG_SEL_W, 3, width of register-file select fields.
- ALU_MODE_W, 3, width of the ALU mode field.
- ACC_SEL, 0, register index written by ALU results.

Ports:
- clk  in  1  sequencer clock.
- reset  in  1  asynchronous, active-low reset.
- ireg  in  8  instruction register contents. [7:4] = opcode, [3:2] = rd, [1:0] = rs.
- flag_zero  in  1  ALU zero flag.
- flag_carry  in  1  ALU carry flag.
- c_rin, c_rou  out  1  register file write / drive bus.
- sel_in, sel_out  out  REG_SEL_W  register selects; rd/rs zero-extended.
- c_aen, c_aou  out  1  ALU compute / drive bus.
- alu_mode  out  ALU_MODE_W  ALU mode; equals ireg[2:0] during ALU instructions, else 0.
- c_mai  out  1  MAR load.
- c_ien  out  1  IR load.
- c_pce  out  1  PC load from bus.
- c_pci  out  1  PC increment.
- c_pcd  out  1  PC decrement; always 0 in this ISA, reserved.
- c_pco  out  1  PC drives bus.
- c_meo  out  1  memory drives bus.
- c_mwe  out  1  memory write.
- flag_z, flag_c  out  1  latched flags.
- halted  out  1  sequencer stopped.
- illegal  out  1  stopped on an undefined opcode.

Behaviour:
- Reset asserted (low):
  - state goes to F0 asynchronously; flag_z, flag_c, halted, illegal = 0.
  - All control outputs are forced to 0 while reset is low, including when it is asserted mid-instruction.
  - First active cycle after release is F0.
- Control outputs are combinational from state and ireg (Moore plus decode). Registers update on the clk rising edge.
- Fetch, common to all instructions:
  - F0: c_pco, c_mai.
  - F1: c_meo, c_ien, c_pci.
  - Then E0.
- Execute steps; the last step returns to F0:
  - 0 NOP: E0 idle. 3 cycles total.
  - 1 MOV: E0 c_rou (sel_out = rs), c_rin (sel_in = rd). 3 cycles.
  - 2 LDI: E0 c_pco, c_mai. E1 c_meo, c_rin (sel_in = rd), c_pci. 4 cycles.
  - 3 LD: E0 c_pco, c_mai. E1 c_meo, c_mai, c_pci. E2 c_meo, c_rin (sel_in = rd). 5 cycles.
  - 4 ST: E0 c_pco, c_mai. E1 c_meo, c_mai, c_pci. E2 c_rou (sel_out = rs), c_mwe. 5 cycles.
  - 5 ALU: E0 c_aen; flag_z/flag_c capture flag_zero/flag_carry at the end of E0. E1 c_aou, c_rin (sel_in = ACC_SEL). 4 cycles.
  - 6 JMP: E0 c_pco, c_mai. E1 c_meo, c_pce. 4 cycles.
  - 7 JZ / 8 JC, condition is latched flag_z / flag_c:
    - Taken: same steps as JMP.
    - Not taken: E0 c_pci only, skipping the operand byte. 3 cycles.
  - F HLT: E0 goes to HALT; halted = 1.
  - 9–E (undefined): E0 goes to HALT; halted = 1, illegal = 1.
- HALT:
  - All controls 0.
  - Exit only by reset.
- Flags change only at the end of ALU E0. A jump in the instruction immediately after an ALU instruction sees the new flags.
- Invariant: at most one of c_rou, c_aou, c_pco, c_meo is high in any cycle.
- Invariant: c_pce and c_pci are never high together.

Optional Feature:
- Macro CU_STEP_EN.
- Defined:
  - Adds input port step (1 bit).
  - After each instruction's final step, the FSM enters WAIT instead of F0. In WAIT all controls are 0 and halted = 0.
  - A rising edge of step, detected via a one-cycle delayed copy, moves WAIT to F0.
  - Holding step high executes exactly one instruction.
  - Reset clears the edge detector and leaves the FSM in F0, not WAIT.
- Undefined: no step port; the FSM returns directly to F0.

Test Plan:
- Reset: drive reset low mid-E1 of LD → all controls drop to 0 immediately. After release, the first cycle shows c_pco = 1, c_mai = 1 (F0).
- MOV then LDI: ireg = 0x16 (MOV r1, r2) → E0 shows sel_out = 2, sel_in = 1, with c_rou and c_rin high. ireg = 0x28 (LDI r2) → 4 cycles, E1 shows sel_in = 2 with c_meo, c_rin, c_pci high.
- ALU then jump:
  - ireg = 0x53 with flag_zero = 1 at E0 → flag_z = 1, alu_mode = 3, and E1 asserts c_aou, c_rin with sel_in = 0.
  - Next ireg = 0x70 (JZ) → taken: E1 shows c_pce high.
  - With flag_zero = 0 instead → JZ takes 3 cycles; E0 shows c_pci only.
- ST: ireg = 0x43 → E2 shows c_mwe = 1, sel_out = 3, c_rou = 1. A bus-contention assertion holds across every cycle of a mixed-instruction program.
- Stop states: ireg = 0xF0 → halted = 1 and stays high for 10 or more cycles. Reset, then ireg = 0xA0 → halted = 1, illegal = 1.
- CU_STEP_EN: NOP program with step held high for 20 cycles → exactly one instruction completes. Each further step pulse → one more F0.

Source files
------------

// File: rtl/control_sequencer.sv
// Fetch/decode/execute control sequencer for the 8-bit single-bus CPU.
// Optional single-step mode is enabled by defining CU_STEP_EN (adds the step input and a WAIT state).
module control_sequencer #(
    parameter int REG_SEL_W  = 3,
    parameter int ALU_MODE_W = 3,
    parameter int ACC_SEL    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef CU_STEP_EN
    input  logic                  step,
`endif
    input  logic [7:0]            ireg,
    input  logic                  flag_zero,
    input  logic                  flag_carry,
    output logic                  c_rin,
    output logic                  c_rou,
    output logic [REG_SEL_W-1:0]  sel_in,
    output logic [REG_SEL_W-1:0]  sel_out,
    output logic                  c_aen,
    output logic                  c_aou,
    output logic [ALU_MODE_W-1:0] alu_mode,
    output logic                  c_mai,
    output logic                  c_ien,
    output logic                  c_pce,
    output logic                  c_pci,
    output logic                  c_pcd,
    output logic                  c_pco,
    output logic                  c_meo,
    output logic                  c_mwe,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  halted,
    output logic                  illegal
);

    typedef enum logic [2:0] {
        S_F0, S_F1, S_E0, S_E1, S_E2, S_HALT, S_WAIT
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_MOV = 4'h1,
        OP_LDI = 4'h2,
        OP_LD  = 4'h3,
        OP_ST  = 4'h4,
        OP_ALU = 4'h5,
        OP_JMP = 4'h6,
        OP_JZ  = 4'h7,
        OP_JC  = 4'h8,
        OP_HLT = 4'hF
    } opcode_t;

    typedef struct packed {
        logic                  rin;
        logic                  rou;
        logic [REG_SEL_W-1:0]  sel_in;
        logic [REG_SEL_W-1:0]  sel_out;
        logic                  aen;
        logic                  aou;
        logic [ALU_MODE_W-1:0] alu_mode;
        logic                  mai;
        logic                  ien;
        logic                  pce;
        logic                  pci;
        logic                  pco;
        logic                  meo;
        logic                  mwe;
    } ctrl_t;

    state_t  state, state_next;
    ctrl_t   ctrl;
    logic    illegal_q;
    logic    illegal_set;
    logic    flag_load;
    logic    jump_taken;
    opcode_t opcode;

    logic [REG_SEL_W-1:0] rd_sel, rs_sel, acc_sel;

    assign opcode  = opcode_t'(ireg[7:4]);
    assign rd_sel  = REG_SEL_W'(ireg[3:2]);
    assign rs_sel  = REG_SEL_W'(ireg[1:0]);
    assign acc_sel = REG_SEL_W'(ACC_SEL);

    assign jump_taken = (opcode == OP_JMP)
                      | ((opcode == OP_JZ) & flag_z)
                      | ((opcode == OP_JC) & flag_c);

`ifdef CU_STEP_EN
    logic step_q;
    logic step_rise;
    localparam state_t S_DONE = S_WAIT;

    assign step_rise = step & ~step_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) step_q <= 1'b0;
        else        step_q <= step;
    end
`else
    localparam state_t S_DONE = S_F0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_F0;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (flag_load) begin
                flag_z <= flag_zero;
                flag_c <= flag_carry;
            end
            if (illegal_set) illegal_q <= 1'b1;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        ctrl        = '0;
        flag_load   = 1'b0;
        illegal_set = 1'b0;

        case (state)
            S_F0: begin
                ctrl.pco   = 1'b1;
                ctrl.mai   = 1'b1;
                state_next = S_F1;
            end
            S_F1: begin
                ctrl.meo   = 1'b1;
                ctrl.ien   = 1'b1;
                ctrl.pci   = 1'b1;
                state_next = S_E0;
            end
            S_E0: begin
                case (opcode)
                    OP_NOP: state_next = S_DONE;
                    OP_MOV: begin
                        ctrl.rou     = 1'b1;
                        ctrl.sel_out = rs_sel;
                        ctrl.rin     = 1'b1;
                        ctrl.sel_in  = rd_sel;
                        state_next   = S_DONE;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        ctrl.pco   = 1'b1;
                        ctrl.mai   = 1'b1;
                        state_next = S_E1;
                    end
                    OP_ALU: begin
                        ctrl.aen      = 1'b1;
                        ctrl.alu_mode = ALU_MODE_W'(ireg[2:0]);
                        flag_load     = 1'b1;
                        state_next    = S_E1;
                    end
                    OP_JMP, OP_JZ, OP_JC: begin
                        if (jump_taken) begin
                            ctrl.pco   = 1'b1;
                            ctrl.mai   = 1'b1;
                            state_next = S_E1;
                        end else begin
                            // Not taken: step the PC over the operand byte.
                            ctrl.pci   = 1'b1;
                            state_next = S_DONE;
                        end
                    end
                    OP_HLT: state_next = S_HALT;
                    default: begin
                        illegal_set = 1'b1;
                        state_next  = S_HALT;
                    end
                endcase
            end
            S_E1: begin
                state_next = S_DONE;
                case (opcode)
                    OP_LDI: begin
                        ctrl.meo    = 1'b1;
                        ctrl.rin    = 1'b1;
                        ctrl.sel_in = rd_sel;
                        ctrl.pci    = 1'b1;
                    end
                    OP_LD, OP_ST: begin
                        ctrl.meo   = 1'b1;
                        ctrl.mai   = 1'b1;
                        ctrl.pci   = 1'b1;
                        state_next = S_E2;
                    end
                    OP_ALU: begin
                        ctrl.aou      = 1'b1;
                        ctrl.rin      = 1'b1;
                        ctrl.sel_in   = acc_sel;
                        ctrl.alu_mode = ALU_MODE_W'(ireg[2:0]);
                    end
                    OP_JMP, OP_JZ, OP_JC: begin
                        ctrl.meo = 1'b1;
                        ctrl.pce = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E2: begin
                state_next = S_DONE;
                if (opcode == OP_LD) begin
                    ctrl.meo    = 1'b1;
                    ctrl.rin    = 1'b1;
                    ctrl.sel_in = rd_sel;
                end else if (opcode == OP_ST) begin
                    ctrl.rou     = 1'b1;
                    ctrl.sel_out = rs_sel;
                    ctrl.mwe     = 1'b1;
                end
            end
            S_HALT: state_next = S_HALT;
`ifdef CU_STEP_EN
            S_WAIT: if (step_rise) state_next = S_F0;
`endif
            default: state_next = S_F0;
        endcase
    end

    // Reset masks the strobes combinationally: the reset state is F0, whose strobes must not reach the datapath.
    always_comb begin
        c_rin    = 1'b0;
        c_rou    = 1'b0;
        sel_in   = '0;
        sel_out  = '0;
        c_aen    = 1'b0;
        c_aou    = 1'b0;
        alu_mode = '0;
        c_mai    = 1'b0;
        c_ien    = 1'b0;
        c_pce    = 1'b0;
        c_pci    = 1'b0;
        c_pco    = 1'b0;
        c_meo    = 1'b0;
        c_mwe    = 1'b0;
        if (reset) begin
            c_rin    = ctrl.rin;
            c_rou    = ctrl.rou;
            sel_in   = ctrl.sel_in;
            sel_out  = ctrl.sel_out;
            c_aen    = ctrl.aen;
            c_aou    = ctrl.aou;
            alu_mode = ctrl.alu_mode;
            c_mai    = ctrl.mai;
            c_ien    = ctrl.ien;
            c_pce    = ctrl.pce;
            c_pci    = ctrl.pci;
            c_pco    = ctrl.pco;
            c_meo    = ctrl.meo;
            c_mwe    = ctrl.mwe;
        end
    end

    assign c_pcd   = 1'b0;
    assign halted  = reset & (state == S_HALT);
    assign illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: stimulus queues the expected control word per cycle,
// a negedge monitor pops and compares it and checks the bus-driver invariants every cycle.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       step;
    logic [7:0] ireg;
    logic       flag_zero, flag_carry;
    logic       c_rin, c_rou, c_aen, c_aou, c_mai, c_ien, c_pce, c_pci, c_pcd;
    logic       c_pco, c_meo, c_mwe, flag_z, flag_c, halted, illegal;
    logic [2:0] sel_in, sel_out, alu_mode;

    always #5 clk = ~clk;

    control_sequencer #(.REG_SEL_W(3), .ALU_MODE_W(3), .ACC_SEL(0)) dut (
        .clk(clk), .reset(reset),
`ifdef CU_STEP_EN
        .step(step),
`endif
        .ireg(ireg), .flag_zero(flag_zero), .flag_carry(flag_carry),
        .c_rin(c_rin), .c_rou(c_rou), .sel_in(sel_in), .sel_out(sel_out),
        .c_aen(c_aen), .c_aou(c_aou), .alu_mode(alu_mode),
        .c_mai(c_mai), .c_ien(c_ien), .c_pce(c_pce), .c_pci(c_pci), .c_pcd(c_pcd),
        .c_pco(c_pco), .c_meo(c_meo), .c_mwe(c_mwe),
        .flag_z(flag_z), .flag_c(flag_c), .halted(halted), .illegal(illegal)
    );

    localparam logic [24:0] RIN = 25'h1000000, ROU = 25'h0800000, AEN = 25'h0010000;
    localparam logic [24:0] AOU = 25'h0008000, MAI = 25'h0000800, IEN = 25'h0000400;
    localparam logic [24:0] PCE = 25'h0000200, PCI = 25'h0000100, PCO = 25'h0000040;
    localparam logic [24:0] MEO = 25'h0000020, MWE = 25'h0000010, HLT = 25'h0000002;
    localparam logic [24:0] ILL = 25'h0000001;

    typedef struct {
        logic [24:0] exp;
        string       name;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  fz_m     = 1'b0;
    logic  fc_m     = 1'b0;

    wire [24:0] act = {c_rin, c_rou, sel_in, sel_out, c_aen, c_aou, alu_mode,
                       c_mai, c_ien, c_pce, c_pci, c_pcd, c_pco, c_meo, c_mwe,
                       flag_z, flag_c, halted, illegal};

    function automatic logic [24:0] f_sin(int v);  return 25'(v) << 20; endfunction
    function automatic logic [24:0] f_sout(int v); return 25'(v) << 17; endfunction
    function automatic logic [24:0] f_am(int v);   return 25'(v) << 12; endfunction

    always @(negedge clk) begin
        item_t it;
        n_checks++;
        if (!$onehot0({c_rou, c_aou, c_pco, c_meo}) || (c_pce && c_pci)) begin
            n_fail++;
            $display("FAIL bus_contention t=%0t got rou/aou/pco/meo=%b pce/pci=%b%b required at most one driver, no pce+pci",
                     $time, {c_rou, c_aou, c_pco, c_meo}, c_pce, c_pci);
        end
        if (sb.size() > 0) begin
            it = sb.pop_front();
            n_checks++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s t=%0t got=%07h required=%07h", it.name, $time, act, it.exp);
            end
        end
    end

    // Queue the expected word for the current cycle, then advance to just after the next edge.
    task automatic cyc(input logic [24:0] e, input string n);
        sb.push_back('{e | (25'({fz_m, fc_m}) << 2), n});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] iv, input logic fz, input logic fc);
        ireg       = iv;
        flag_zero  = fz;
        flag_carry = fc;
        cyc(PCO | MAI, "f0");
        cyc(MEO | IEN | PCI, "f1");
    endtask

    task automatic end_instr();
`ifdef CU_STEP_EN
        cyc('0, "wait");
        step = 1'b1;
        cyc('0, "wait_edge");
        step = 1'b0;
`endif
    endtask

    initial begin
        reset      = 1'b0;
        step       = 1'b0;
        ireg       = 8'h00;
        flag_zero  = 1'b0;
        flag_carry = 1'b0;
        @(posedge clk);
        #1;
        cyc('0, "reset_hold0");
        cyc('0, "reset_hold1");
        reset = 1'b1;

        fetch(8'h00, 1'b0, 1'b0); cyc('0, "nop_e0"); end_instr();

        fetch(8'h16, 1'b0, 1'b0);
        cyc(ROU | RIN | f_sout(2) | f_sin(1), "mov_e0"); end_instr();

        fetch(8'h28, 1'b0, 1'b0);
        cyc(PCO | MAI, "ldi_e0");
        cyc(MEO | RIN | PCI | f_sin(2), "ldi_e1"); end_instr();

        fetch(8'h53, 1'b1, 1'b0);
        cyc(AEN | f_am(3), "alu53_e0");
        fz_m = 1'b1; fc_m = 1'b0;
        cyc(AOU | RIN | f_sin(0) | f_am(3), "alu53_e1"); end_instr();

        fetch(8'h70, 1'b0, 1'b0);
        cyc(PCO | MAI, "jz_taken_e0");
        cyc(MEO | PCE, "jz_taken_e1"); end_instr();

        fetch(8'h51, 1'b0, 1'b1);
        cyc(AEN | f_am(1), "alu51_e0");
        fz_m = 1'b0; fc_m = 1'b1;
        cyc(AOU | RIN | f_sin(0) | f_am(1), "alu51_e1"); end_instr();

        fetch(8'h70, 1'b1, 1'b0);
        cyc(PCI, "jz_not_taken_e0"); end_instr();

        fetch(8'h80, 1'b0, 1'b0);
        cyc(PCO | MAI, "jc_taken_e0");
        cyc(MEO | PCE, "jc_taken_e1"); end_instr();

        fetch(8'h43, 1'b0, 1'b0);
        cyc(PCO | MAI, "st_e0");
        cyc(MEO | MAI | PCI, "st_e1");
        cyc(ROU | MWE | f_sout(3), "st_e2"); end_instr();

        fetch(8'h3C, 1'b0, 1'b0);
        cyc(PCO | MAI, "ld_e0");
        cyc(MEO | MAI | PCI, "ld_e1");
        cyc(MEO | RIN | f_sin(3), "ld_e2"); end_instr();

        fetch(8'h34, 1'b0, 1'b0);
        cyc(PCO | MAI, "ld_e0_pre_reset");
        reset = 1'b0;
        fz_m = 1'b0; fc_m = 1'b0;
        cyc('0, "reset_mid_ld_e1");
        cyc('0, "reset_mid_hold");
        reset = 1'b1;

        fetch(8'hF0, 1'b0, 1'b0);
        cyc('0, "hlt_e0");
        ireg = 8'h00;
        for (int i = 0; i < 12; i++) cyc(HLT, "halt_hold");

        reset = 1'b0;
        cyc('0, "reset_from_halt");
        reset = 1'b1;
        fetch(8'hA0, 1'b0, 1'b0);
        cyc('0, "undef_e0");
        for (int i = 0; i < 3; i++) cyc(HLT | ILL, "illegal_hold");

`ifdef CU_STEP_EN
        reset = 1'b0;
        cyc('0, "reset_before_step");
        step  = 1'b1;
        reset = 1'b1;
        fetch(8'h00, 1'b0, 1'b0);
        cyc('0, "step_nop_e0");
        for (int i = 0; i < 17; i++) cyc('0, "step_held_wait");
        for (int p = 0; p < 2; p++) begin
            step = 1'b0;
            cyc('0, "step_low_wait");
            step = 1'b1;
            cyc('0, "step_pulse_wait");
            fetch(8'h00, 1'b0, 1'b0);
            cyc('0, "step_pulse_nop_e0");
            cyc('0, "step_pulse_back_to_wait");
        end
        step = 1'b0;
`endif

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
        end
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
